// File: rtl/chk_pkg.sv
// Shared types and constants for the DAC loopback checker: FSM states,
// widths and the offset-binary to signed sample conversion.
package chk_pkg;

    localparam int CHK_DW = 14;
    localparam int LAT_W  = 6;

    localparam logic [CHK_DW-1:0] OFFSET_CODE = 14'd8191;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FILL  = 2'd2,
        ST_CHECK = 2'd3
    } chk_state_e;

    // Offset-binary code to two's complement; wraps mod 2^DW by construction.
    function automatic logic signed [CHK_DW-1:0] to_signed_sample(input logic [CHK_DW-1:0] code);
        return OFFSET_CODE - code;
    endfunction

endpackage

// File: rtl/chk_sample_fifo.sv
// Single-clock sample FIFO used as the programmable delay line of the checker.
// Read data is the current head (first-word fall-through); flush empties it in one cycle.
module chk_sample_fifo #(
    parameter int DW    = 14,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DW-1:0]            wr_data_i,
    output logic [DW-1:0]            rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Overflowing pushes and underflowing pops are dropped rather than corrupting state.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dac_loopback_checker.sv
// Delays captured ADC samples by the configured datapath latency and compares
// them with the DAC output code, accumulating miscompare statistics.
module dac_loopback_checker
    import chk_pkg::*;
#(
    parameter int DW    = CHK_DW,
    parameter int DEPTH = 64,
    parameter int TOL   = 1
) (
    input  logic              adc_clk_i,
    input  logic              adc_rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [5:0]        cfg_latency_i,
    input  logic [DW-1:0]     adc_dat_i,
    input  logic [DW-1:0]     dac_dat_i,
    output logic [1:0]        state_o,
    output logic              cfg_err_o,
    output logic              err_o,
    output logic              err_sticky_o,
    output logic [31:0]       chk_cnt_o,
    output logic [31:0]       err_cnt_o,
    output logic [DW-1:0]     max_err_o
);

    chk_state_e          state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [LAT_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic                cfg_err_q, cfg_err_d;
    logic                err_q, err_d;
    logic                sticky_q, sticky_d;
    logic [31:0]         chk_cnt_q, chk_cnt_d;
    logic [31:0]         err_cnt_q, err_cnt_d;
    logic [DW-1:0]       max_err_q, max_err_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic [DW-1:0]       fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                fifo_unused;

    logic                latency_ok;
    logic signed [DW-1:0] ref_s, dut_s;
    logic signed [DW-1:0] ref_f, dut_f, diff;
    logic [DW-1:0]       abs_diff;
    logic                miss;
    logic                cmp_valid;

    chk_sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (adc_clk_i),
        .rst_i     (adc_rst_i),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .flush_i   (fifo_flush),
        .wr_data_i (adc_dat_i),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign fifo_unused = ^{fifo_full, fifo_level};

    assign latency_ok = (cfg_latency_i != '0) && (int'(cfg_latency_i) < DEPTH);

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        fill_cnt_d = fill_cnt_q;
        cfg_err_d  = cfg_err_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        if (!en_i) begin
            state_d    = ST_IDLE;
            fill_cnt_d = '0;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (latency_ok) begin
                        state_d   = ST_WAIT;
                        lat_d     = cfg_latency_i;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A latency of one needs no fill cycle: the trigger push is the whole delay.
                    if (dac_dat_i != '0) begin
                        fifo_push  = 1'b1;
                        fill_cnt_d = LAT_W'(1);
                        state_d    = (lat_q == LAT_W'(1)) ? ST_CHECK : ST_FILL;
                    end
                end
                ST_FILL: begin
                    fifo_push  = 1'b1;
                    fill_cnt_d = fill_cnt_q + LAT_W'(1);
                    if (fill_cnt_d == lat_q) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    fifo_push = 1'b1;
                    fifo_pop  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Only the upper DW-1 bits take part, so the LSB of each sample is ignored.
    always_comb begin
        ref_s     = to_signed_sample(fifo_rd_data);
        dut_s     = to_signed_sample(dac_dat_i);
        ref_f     = {ref_s[DW-1], ref_s[DW-1:1]};
        dut_f     = {dut_s[DW-1], dut_s[DW-1:1]};
        diff      = dut_f - ref_f;
        abs_diff  = diff[DW-1] ? -diff : diff;
        miss      = abs_diff > DW'(TOL);
        cmp_valid = fifo_pop && !fifo_empty;
    end

    always_comb begin
        err_d     = 1'b0;
        sticky_d  = sticky_q;
        chk_cnt_d = chk_cnt_q;
        err_cnt_d = err_cnt_q;
        max_err_d = max_err_q;
        if (clr_i) begin
            sticky_d  = 1'b0;
            chk_cnt_d = '0;
            err_cnt_d = '0;
            max_err_d = '0;
        end else if (cmp_valid) begin
            chk_cnt_d = (chk_cnt_q == '1) ? chk_cnt_q : chk_cnt_q + 32'd1;
            if (miss) begin
                err_d     = 1'b1;
                sticky_d  = 1'b1;
                err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
            end
            if (abs_diff > max_err_q) begin
                max_err_d = abs_diff;
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            fill_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            chk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            max_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            fill_cnt_q <= fill_cnt_d;
            cfg_err_q  <= cfg_err_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            chk_cnt_q  <= chk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            max_err_q  <= max_err_d;
        end
    end

    assign state_o      = state_q;
    assign cfg_err_o    = cfg_err_q;
    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;
    assign chk_cnt_o    = chk_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign max_err_o    = max_err_q;

endmodule

// File: tb/tb_dac_loopback_checker.sv
// Randomized bench for dac_loopback_checker: a noisy sine source feeds the ADC and a
// delayed/offset copy feeds the DAC; a queue-based delay-line model predicts every output.
module tb_dac_loopback_checker;

    localparam int     DW      = 14;
    localparam int     DEPTH   = 64;
    localparam int     TOL     = 1;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic           adc_clk_i = 1'b0;
    logic           adc_rst_i;
    logic           en_i;
    logic           clr_i;
    logic [5:0]     cfg_latency_i;
    logic [DW-1:0]  adc_dat_i;
    logic [DW-1:0]  dac_dat_i;
    logic [1:0]     state_o;
    logic           cfg_err_o;
    logic           err_o;
    logic           err_sticky_o;
    logic [31:0]    chk_cnt_o;
    logic [31:0]    err_cnt_o;
    logic [DW-1:0]  max_err_o;

    always #4 adc_clk_i = ~adc_clk_i;

    dac_loopback_checker #(.DW(DW), .DEPTH(DEPTH), .TOL(TOL)) dut (
        .adc_clk_i     (adc_clk_i),
        .adc_rst_i     (adc_rst_i),
        .en_i          (en_i),
        .clr_i         (clr_i),
        .cfg_latency_i (cfg_latency_i),
        .adc_dat_i     (adc_dat_i),
        .dac_dat_i     (dac_dat_i),
        .state_o       (state_o),
        .cfg_err_o     (cfg_err_o),
        .err_o         (err_o),
        .err_sticky_o  (err_sticky_o),
        .chk_cnt_o     (chk_cnt_o),
        .err_cnt_o     (err_cnt_o),
        .max_err_o     (max_err_o)
    );

    int     vectors     = 0;
    int     miscompares = 0;
    int     period      = 256;
    int     src_hist[$];

    // Reference model: phase 0 disabled, 1 armed, 2 synced; m_q is the delay line.
    int     m_phase = 0;
    int     m_lat   = 0;
    int     m_max   = 0;
    int     m_q[$];
    bit     m_cfg_err = 0;
    bit     m_err     = 0;
    bit     m_sticky  = 0;
    longint m_chk     = 0;
    longint m_errc    = 0;

    function automatic int to_s(input int code);
        int s;
        s = (8191 - code) & 16383;
        if (s >= 8192) s = s - 16384;
        return s;
    endfunction

    function automatic int sine_code(input int n);
        real ph;
        ph = 2.0 * 3.141592653589793 * real'(n) / real'(period);
        return 8191 - $rtoi(4096.0 * $sin(ph)) + int'($urandom_range(0, 3));
    endfunction

    function automatic int exp_state();
        if (m_phase == 0) return 0;
        if (m_phase == 1) return 1;
        return (m_q.size() == m_lat) ? 3 : 2;
    endfunction

    task automatic model_update(input bit rst, input bit en, input bit clr,
                                input int lat, input int adc, input int dac);
        bit compared;
        int absd;
        int d;
        int rf;
        compared = 0;
        absd     = 0;
        m_err    = 0;
        if (rst) begin
            m_phase = 0; m_lat = 0; m_max = 0; m_q.delete();
            m_cfg_err = 0; m_sticky = 0; m_chk = 0; m_errc = 0;
        end else begin
            if (!en) begin
                m_phase = 0;
                m_q.delete();
            end else if (m_phase == 0) begin
                if (lat >= 1 && lat <= DEPTH - 1) begin
                    m_phase = 1; m_lat = lat; m_cfg_err = 0;
                end else begin
                    m_cfg_err = 1;
                end
            end else if (m_phase == 1) begin
                if (dac != 0) begin
                    m_phase = 2;
                    m_q.push_back(adc);
                end
            end else begin
                if (m_q.size() == m_lat) begin
                    rf = m_q.pop_front();
                    compared = 1;
                    d = (to_s(dac) >>> 1) - (to_s(rf) >>> 1);
                    absd = (d < 0) ? -d : d;
                end
                m_q.push_back(adc);
            end
            if (clr) begin
                m_chk = 0; m_errc = 0; m_max = 0; m_sticky = 0;
            end else if (compared) begin
                if (m_chk < CNT_MAX) m_chk++;
                if (absd > TOL) begin
                    m_err = 1; m_sticky = 1;
                    if (m_errc < CNT_MAX) m_errc++;
                end
                if (absd > m_max) m_max = absd;
            end
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit en, input bit clr,
                               input int lat, input int delay, input int off);
        int n;
        int code;
        int dac;
        n    = src_hist.size();
        code = sine_code(n);
        src_hist.push_back(code);
        dac  = (n >= delay) ? src_hist[n - delay] + off : 0;
        adc_rst_i     = rst;
        en_i          = en;
        clr_i         = clr;
        cfg_latency_i = 6'(lat);
        adc_dat_i     = DW'(code);
        dac_dat_i     = DW'(dac);
        @(posedge adc_clk_i);
        model_update(rst, en, clr, lat, code, dac);
        #1;
    endtask

    always @(negedge adc_clk_i) begin
        if (adc_rst_i === 1'b0) begin
            if (dut.u_fifo.push_i === 1'b1 && dut.u_fifo.full_o === 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fifo_push_full: push while full, level=%0d", dut.u_fifo.level_o);
            end
            if (dut.u_fifo.pop_i === 1'b1 && dut.u_fifo.empty_o === 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fifo_pop_empty: pop while empty");
            end
        end
    end

    task automatic test_reset();
        drive_cycle(1, 0, 0, 0, 30, 0);
        drive_cycle(1, 0, 0, 0, 30, 0);
        vectors++;
        if (state_o !== 2'd0 || cfg_err_o !== 1'b0 || err_o !== 1'b0 || err_sticky_o !== 1'b0 ||
            chk_cnt_o !== 32'd0 || err_cnt_o !== 32'd0 || max_err_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset: state=%0d cfg_err=%0b err=%0b sticky=%0b chk=%0d errc=%0d max=%0d, required all 0",
                     state_o, cfg_err_o, err_o, err_sticky_o, chk_cnt_o, err_cnt_o, max_err_o);
        end
    endtask

    task automatic test_cfg_error();
        logic [6:0] l64;
        l64 = 7'd64;
        drive_cycle(0, 0, 0, 0, 30, 0);
        drive_cycle(0, 1, 0, 0, 30, 0);
        vectors++;
        if (state_o !== 2'd0 || cfg_err_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cfg_lat0: state=%0d cfg_err=%0b, required 0/1", state_o, cfg_err_o);
        end
        drive_cycle(0, 1, 0, int'(l64[5:0]), 30, 0);
        vectors++;
        if (state_o !== 2'd0 || cfg_err_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cfg_lat64: state=%0d cfg_err=%0b, required 0/1", state_o, cfg_err_o);
        end
        drive_cycle(0, 1, 0, 16, 30, 0);
        vectors++;
        if (state_o !== 2'd1 || cfg_err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cfg_lat16: state=%0d cfg_err=%0b, required 1/0", state_o, cfg_err_o);
        end
        drive_cycle(0, 0, 0, 16, 30, 0);
        vectors++;
        if (state_o !== 2'd0 || cfg_err_o !== m_cfg_err) begin
            miscompares++;
            $display("[TB] FAIL cfg_disable: state=%0d cfg_err=%0b, required 0/%0b", state_o, cfg_err_o, m_cfg_err);
        end
    endtask

    task automatic test_identity();
        drive_cycle(0, 0, 0, 30, 30, 0);
        for (int i = 0; i < 150; i++) begin
            drive_cycle(0, 1, 0, 30, 30, 0);
            vectors++;
            if (state_o !== 2'(exp_state()) || err_o !== m_err || chk_cnt_o !== 32'(m_chk) ||
                err_cnt_o !== 32'(m_errc) || max_err_o !== DW'(m_max)) begin
                miscompares++;
                $display("[TB] FAIL identity c%0d: state=%0d/%0d err=%0b/%0b chk=%0d/%0d errc=%0d/%0d max=%0d/%0d",
                         i, state_o, exp_state(), err_o, m_err, chk_cnt_o, m_chk, err_cnt_o, m_errc, max_err_o, m_max);
            end
        end
        vectors++;
        if (state_o !== 2'd3 || err_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL identity_end: state=%0d errc=%0d, required 3/0", state_o, err_cnt_o);
        end
    endtask

    task automatic test_offset();
        for (int i = 0; i < 120; i++) begin
            drive_cycle(0, 1, 0, 30, 30, (i < 60) ? 2 : 4);
            vectors++;
            if (err_o !== m_err || err_cnt_o !== 32'(m_errc) || max_err_o !== DW'(m_max) ||
                chk_cnt_o !== 32'(m_chk) || err_sticky_o !== m_sticky) begin
                miscompares++;
                $display("[TB] FAIL offset c%0d: err=%0b/%0b errc=%0d/%0d max=%0d/%0d chk=%0d/%0d sticky=%0b/%0b",
                         i, err_o, m_err, err_cnt_o, m_errc, max_err_o, m_max, chk_cnt_o, m_chk, err_sticky_o, m_sticky);
            end
            if (i == 59) begin
                vectors++;
                if (err_cnt_o !== 32'd0 || max_err_o !== 14'd1) begin
                    miscompares++;
                    $display("[TB] FAIL offset2: errc=%0d max=%0d, required 0/1", err_cnt_o, max_err_o);
                end
            end
        end
        vectors++;
        if (err_o !== 1'b1 || max_err_o !== 14'd2) begin
            miscompares++;
            $display("[TB] FAIL offset4: err=%0b max=%0d, required 1/2", err_o, max_err_o);
        end
    endtask

    task automatic test_latency_mismatch();
        drive_cycle(0, 0, 1, 28, 30, 0);
        drive_cycle(0, 0, 0, 28, 30, 0);
        for (int i = 0; i < 150; i++) begin
            drive_cycle(0, 1, 0, 28, 30, 0);
            vectors++;
            if (state_o !== 2'(exp_state()) || err_o !== m_err || chk_cnt_o !== 32'(m_chk) ||
                err_cnt_o !== 32'(m_errc) || max_err_o !== DW'(m_max) || err_sticky_o !== m_sticky) begin
                miscompares++;
                $display("[TB] FAIL mismatch c%0d: state=%0d/%0d err=%0b/%0b chk=%0d/%0d errc=%0d/%0d max=%0d/%0d",
                         i, state_o, exp_state(), err_o, m_err, chk_cnt_o, m_chk, err_cnt_o, m_errc, max_err_o, m_max);
            end
        end
        vectors++;
        if (err_sticky_o !== 1'b1 || err_cnt_o == 32'd0) begin
            miscompares++;
            $display("[TB] FAIL mismatch_end: sticky=%0b errc=%0d, required 1/nonzero", err_sticky_o, err_cnt_o);
        end
    endtask

    task automatic test_enable_drop();
        longint base;
        int     w;
        int     c;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 0, 0, 30, 30, 0);
            vectors++;
            if (state_o !== 2'd0 || dut.u_fifo.level_o !== '0 || chk_cnt_o !== 32'(m_chk) || err_cnt_o !== 32'(m_errc)) begin
                miscompares++;
                $display("[TB] FAIL en_drop c%0d: state=%0d level=%0d chk=%0d/%0d errc=%0d/%0d",
                         i, state_o, dut.u_fifo.level_o, chk_cnt_o, m_chk, err_cnt_o, m_errc);
            end
        end
        base = m_chk;
        w = -1;
        c = -1;
        for (int i = 0; i < 80; i++) begin
            drive_cycle(0, 1, 0, 30, 30, 0);
            if (w < 0 && state_o === 2'd1) w = i;
            if (c < 0 && chk_cnt_o !== 32'(base)) c = i;
            vectors++;
            if (state_o !== 2'(exp_state()) || err_o !== m_err || chk_cnt_o !== 32'(m_chk) || err_cnt_o !== 32'(m_errc)) begin
                miscompares++;
                $display("[TB] FAIL resync c%0d: state=%0d/%0d err=%0b/%0b chk=%0d/%0d errc=%0d/%0d",
                         i, state_o, exp_state(), err_o, m_err, chk_cnt_o, m_chk, err_cnt_o, m_errc);
            end
        end
        vectors++;
        if (w < 0 || c < 0 || c - w != 31) begin
            miscompares++;
            $display("[TB] FAIL resync_latency: wait@%0d first count@%0d, required distance 31", w, c);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 30, 30, 4);
        drive_cycle(0, 1, 1, 30, 30, 4);
        vectors++;
        if (chk_cnt_o !== 32'd0 || err_cnt_o !== 32'd0 || max_err_o !== '0 || err_sticky_o !== 1'b0 || err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear: chk=%0d errc=%0d max=%0d sticky=%0b err=%0b, required all 0",
                     chk_cnt_o, err_cnt_o, max_err_o, err_sticky_o, err_o);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 0, 30, 30, 4);
            vectors++;
            if (err_o !== m_err || chk_cnt_o !== 32'(m_chk) || err_cnt_o !== 32'(m_errc) || max_err_o !== DW'(m_max)) begin
                miscompares++;
                $display("[TB] FAIL after_clear c%0d: err=%0b/%0b chk=%0d/%0d errc=%0d/%0d max=%0d/%0d",
                         i, err_o, m_err, chk_cnt_o, m_chk, err_cnt_o, m_errc, max_err_o, m_max);
            end
        end
    endtask

    task automatic test_saturation();
        force dut.err_cnt_q = 32'hFFFF_FFFF;
        m_errc = CNT_MAX;
        drive_cycle(0, 1, 0, 30, 30, 4);
        drive_cycle(0, 1, 0, 30, 30, 4);
        release dut.err_cnt_q;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(0, 1, 0, 30, 30, 4);
            vectors++;
            if (err_cnt_o !== 32'(m_errc) || err_cnt_o !== 32'hFFFF_FFFF || err_o !== m_err) begin
                miscompares++;
                $display("[TB] FAIL saturation c%0d: errc=%0h required %0h, err=%0b/%0b",
                         i, err_cnt_o, 32'(m_errc), err_o, m_err);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        drive_cycle(1, 1, 0, 30, 30, 4);
        vectors++;
        if (state_o !== 2'd0 || cfg_err_o !== 1'b0 || err_o !== 1'b0 || err_sticky_o !== 1'b0 ||
            chk_cnt_o !== 32'd0 || err_cnt_o !== 32'd0 || max_err_o !== '0 || dut.u_fifo.level_o !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: state=%0d err=%0b sticky=%0b chk=%0d errc=%0d max=%0d level=%0d, required all 0",
                     state_o, err_o, err_sticky_o, chk_cnt_o, err_cnt_o, max_err_o, dut.u_fifo.level_o);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 1, 0, 30, 30, 4);
            vectors++;
            if (state_o !== 2'(exp_state()) || err_o !== m_err || chk_cnt_o !== 32'(m_chk)) begin
                miscompares++;
                $display("[TB] FAIL post_reset c%0d: state=%0d/%0d err=%0b/%0b chk=%0d/%0d",
                         i, state_o, exp_state(), err_o, m_err, chk_cnt_o, m_chk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_error();
        test_identity();
        test_offset();
        test_latency_mismatch();
        test_enable_drop();
        test_clear();
        test_saturation();
        test_reset_mid_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
